// File: rtl/decode_queue_stage.sv
// Instruction queue (circular buffer) followed by an RV32I decoder and a registered decode bundle.
// Optional macro RV32M_EN enables decoding of the RV32M multiply/divide encodings.
module decode_queue_stage #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [31:0]           out_imm,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_alu_op,
    output logic                  out_alu_signed,
    output logic                  out_op1_pc,
    output logic                  out_op2_imm,
    output logic                  out_regwrite,
    output logic                  out_jump,
    output logic                  out_jr,
    output logic                  out_br,
    output logic                  out_load,
    output logic                  out_store,
    output logic                  out_mret,
    output logic [1:0]            out_mem_size,
    output logic                  out_mem_signed,
    output logic [1:0]            out_csr_op,
    output logic                  out_csr_imm,
    output logic                  out_exc,
    output logic [3:0]            out_exc_cause,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  alu_op;
        logic        alu_signed;
        logic        op1_pc;
        logic        op2_imm;
        logic        regwrite;
        logic        jump;
        logic        jr;
        logic        br;
        logic        load;
        logic        store;
        logic        mret;
        logic [1:0]  mem_size;
        logic        mem_signed;
        logic [1:0]  csr_op;
        logic        csr_imm;
        logic        exc;
        logic [3:0]  exc_cause;
    } dec_t;

    logic [31:0]         inst_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                push, pop, ill;
    logic [31:0]         h;
    logic [2:0]          f3;
    logic [6:0]          f7;
    dec_t                d, out_q;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on occupancy, so a pop never frees a slot for the same edge.
    assign in_ready  = (count < FULL);
    assign push      = in_valid && in_ready;
    assign pop       = (count != '0) && (!out_valid || out_ready);
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    function automatic logic [4:0] alu_of(input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  alu_of = alt ? 5'd1 : 5'd0;
            3'b001:  alu_of = 5'd2;
            3'b010:  alu_of = 5'd3;
            3'b011:  alu_of = 5'd3;
            3'b100:  alu_of = 5'd4;
            3'b101:  alu_of = alt ? 5'd6 : 5'd5;
            3'b110:  alu_of = 5'd7;
            default: alu_of = 5'd8;
        endcase
    endfunction

    assign h  = inst_mem[rd_ptr];
    assign f3 = h[14:12];
    assign f7 = h[31:25];

    always_comb begin
        d            = '0;
        ill          = 1'b0;
        d.rs1        = h[19:15];
        d.rs2        = h[24:20];
        d.rd         = h[11:7];
        d.alu_signed = 1'b1;
        if (h[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (h[6:2])
                5'b00100: begin
                    d.regwrite   = 1'b1;
                    d.op2_imm    = 1'b1;
                    d.alu_op     = alu_of(f3, (f3 == 3'b101) && h[30]);
                    d.alu_signed = (f3 != 3'b011);
                    if (f3 == 3'b001 || f3 == 3'b101) d.imm = {27'd0, h[24:20]};
                    else                              d.imm = {{20{h[31]}}, h[31:20]};
                end
                5'b01101: begin
                    d.regwrite = 1'b1;
                    d.op2_imm  = 1'b1;
                    d.rs1      = 5'd0;
                    d.imm      = {h[31:12], 12'd0};
                end
                5'b00101: begin
                    d.regwrite = 1'b1;
                    d.op1_pc   = 1'b1;
                    d.op2_imm  = 1'b1;
                    d.imm      = {h[31:12], 12'd0};
                end
                5'b01100: begin
                    d.regwrite   = 1'b1;
                    d.alu_signed = (f3 != 3'b011);
                    if (f7 == 7'b0000000 ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                        d.alu_op = alu_of(f3, h[30]);
`ifdef RV32M_EN
                    else if (f7 == 7'b0000001)
                        d.alu_op = 5'd9 + {2'b00, f3};
`endif
                    else
                        ill = 1'b1;
                end
                5'b11011: begin
                    d.regwrite = 1'b1;
                    d.jump     = 1'b1;
                    d.imm      = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
                end
                5'b11001: begin
                    d.regwrite = 1'b1;
                    d.jr       = 1'b1;
                    d.op2_imm  = 1'b1;
                    d.imm      = {{20{h[31]}}, h[31:20]};
                end
                5'b11000: begin
                    d.br  = 1'b1;
                    d.imm = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
                    ill   = (f3 == 3'b010) || (f3 == 3'b011);
                end
                5'b00000: begin
                    d.regwrite   = 1'b1;
                    d.load       = 1'b1;
                    d.op2_imm    = 1'b1;
                    d.imm        = {{20{h[31]}}, h[31:20]};
                    d.mem_size   = f3[1:0];
                    d.mem_signed = !f3[2];
                    ill          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                end
                5'b01000: begin
                    d.store    = 1'b1;
                    d.op2_imm  = 1'b1;
                    d.imm      = {{20{h[31]}}, h[31:25], h[11:7]};
                    d.mem_size = f3[1:0];
                    ill        = (f3[2] || f3[1:0] == 2'b11);
                end
                5'b00011: ;
                5'b11100: begin
                    if (f3 == 3'b000) begin
                        if (h == 32'h0000_0073) begin
                            d.exc       = 1'b1;
                            d.exc_cause = 4'd11;
                        end else if (h == 32'h0010_0073) begin
                            d.exc       = 1'b1;
                            d.exc_cause = 4'd3;
                        end else if (h == 32'h3020_0073) begin
                            d.mret = 1'b1;
                        end else begin
                            ill = 1'b1;
                        end
                    end else if (f3 == 3'b100) begin
                        ill = 1'b1;
                    end else begin
                        d.csr_op   = f3[1:0];
                        d.csr_imm  = f3[2];
                        d.regwrite = 1'b1;
                        d.imm      = {20'd0, h[31:20]};
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin
            d.exc       = 1'b1;
            d.exc_cause = 4'd2;
        end
        // A faulting instruction must not leave any side effect behind in later stages.
        if (d.exc) begin
            d.regwrite   = 1'b0;
            d.store      = 1'b0;
            d.load       = 1'b0;
            d.br         = 1'b0;
            d.jump       = 1'b0;
            d.jr         = 1'b0;
            d.mret       = 1'b0;
            d.op1_pc     = 1'b0;
            d.op2_imm    = 1'b0;
            d.mem_size   = 2'd0;
            d.mem_signed = 1'b0;
            d.csr_op     = 2'd0;
            d.csr_imm    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_q     <= d;
            out_inst  <= h;
            out_pc    <= pc_mem[rd_ptr];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_imm        = out_q.imm;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_rd         = out_q.rd;
    assign out_alu_op     = out_q.alu_op;
    assign out_alu_signed = out_q.alu_signed;
    assign out_op1_pc     = out_q.op1_pc;
    assign out_op2_imm    = out_q.op2_imm;
    assign out_regwrite   = out_q.regwrite;
    assign out_jump       = out_q.jump;
    assign out_jr         = out_q.jr;
    assign out_br         = out_q.br;
    assign out_load       = out_q.load;
    assign out_store      = out_q.store;
    assign out_mret       = out_q.mret;
    assign out_mem_size   = out_q.mem_size;
    assign out_mem_signed = out_q.mem_signed;
    assign out_csr_op     = out_q.csr_op;
    assign out_csr_imm    = out_q.csr_imm;
    assign out_exc        = out_q.exc;
    assign out_exc_cause  = out_q.exc_cause;
endmodule

// File: doc/decode_queue_stage.md
DECODE_QUEUE_STAGE -- requirements
Module: decode_queue_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries, power of two, >= 2.
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of the carried PC.
REQ-003 SHALL have one clock and a synchronous, active-low reset. Ports:
- clk  in  1  rising-edge clock.
- resetb  in  1  synchronous active-low reset.
- flush  in  1  discard all queued and output-registered instructions.
- in_valid / in_ready  in / out  1  fetch handshake.
- in_inst / in_pc  in  32 / PC_WIDTH  fetched instruction and its PC.
- out_valid / out_ready  out / in  1  decode-bundle handshake.
- out_inst / out_pc  out  32 / PC_WIDTH  instruction and PC passed through.
- out_imm  out  32  sign/zero-extended immediate.
- out_rs1, out_rs2, out_rd  out  5 each  register addresses.
- out_alu_op  out  5  ALU operation code.
- out_alu_signed, out_op1_pc, out_op2_imm  out  1 each  ALU controls.
- out_regwrite, out_jump, out_jr, out_br, out_load, out_store, out_mret  out  1 each  controls.
- out_mem_size / out_mem_signed  out  2 / 1  memory access: 0 byte, 1 half, 2 word; sign extension.
- out_csr_op / out_csr_imm  out  2 / 1  CSR operation: 0 none, 1 RW, 2 RS, 3 RC; immediate form.
- out_exc / out_exc_cause  out  1 / 4  decode exception and mcause code.
- occupancy  out  clog2(DEPTH)+1  entries currently queued.

Function
REQ-004 Push SHALL occur on a clock edge when in_valid && in_ready; in_ready = (occupancy < DEPTH), independent of pop.
REQ-005 At full, a simultaneous pop SHALL NOT enable a push in the same cycle.
REQ-006 Queue SHALL be a circular buffer; read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-007 Head entry SHALL be decoded combinationally and loaded into the output register when the queue is non-empty and (!out_valid || out_ready).
REQ-008 Latency SHALL be exactly 2 edges from push to out_valid when the queue is empty and the output register is free.
REQ-009 Sustained throughput SHALL be one bundle per cycle while out_ready = 1.
REQ-010 Output fields SHALL stay stable while out_valid && !out_ready.
REQ-011 Decoding SHALL cover RV32I: OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM (treated as NOP), SYSTEM.
REQ-012 Immediate formats SHALL be I, U, J, B, S; SLLI/SRLI/SRAI SHALL give a zero-extended shamt.
REQ-013 out_alu_op SHALL be: ADD 0, SUB 1, SLL 2, SLT 3, XOR 4, SRL 5, SRA 6, OR 7, AND 8; SLTU/SLTIU SHALL be SLT with out_alu_signed = 0.
REQ-014 LUI SHALL force out_rs1 = 0; AUIPC SHALL set out_op1_pc.
REQ-015 out_exc_cause SHALL be:
- 2 for illegal instruction: opcode[1:0] != 2'b11, unsupported opcode, bad funct3 for BRANCH/LOAD/STORE, SRET/WFI/URET, or other SYSTEM funct7.
- 3 for EBREAK.
- 11 for ECALL.
REQ-016 MRET (0x30200073) SHALL set out_mret with no exception.
REQ-017 When out_exc = 1, out_regwrite, out_store and out_csr_op SHALL be 0.
REQ-018 Alignment checks SHALL NOT be performed here; they belong to execute.
REQ-019 flush SHALL clear the queue, pointers and out_valid on the next edge; a push requested in the same cycle SHALL be dropped; flush SHALL have priority over push and pop.

Reset
REQ-020 On an edge with resetb = 0: occupancy, pointers and out_valid SHALL be 0, and in_ready SHALL be 1 after that edge.
REQ-021 On reset, all out_* control flags SHALL be 0 and out_exc_cause SHALL be 0.
REQ-022 Reset SHALL override flush and in-flight handshakes.

Configuration
REQ-023 With RV32M_EN defined, OP with funct7 = 0000001 SHALL decode to MUL 9, MULH 10, MULHSU 11, MULHU 12, DIV 13, DIVU 14, REM 15, REMU 16, with out_regwrite = 1.
REQ-024 Without RV32M_EN, the same encodings SHALL raise out_exc with cause 2.

Verification
REQ-025 Push 0x00500093 (ADDI x1,x0,5) into an empty queue with out_ready = 1 -> out_valid 2 edges later; out_imm = 5, out_rd = 1, out_alu_op = 0, out_regwrite = 1.
REQ-026 Push 0x40335293 (SRAI x5,x6,3) -> out_alu_op = 6, out_imm = 3, out_op2_imm = 1.
REQ-027 Push ECALL 0x00000073, EBREAK 0x00100073 and MRET 0x30200073 -> causes 11 and 3, then out_mret = 1 with out_exc = 0.
REQ-028 out_ready = 0, push DEPTH instructions -> in_ready = 0 and occupancy = DEPTH; raise out_ready -> bundles emerge in push order across pointer wrap.
REQ-029 Assert flush with in_valid = 1 and a full queue -> next cycle occupancy = 0, out_valid = 0, pushed word lost.
REQ-030 Push 0x022081B3 (MUL x3,x1,x2) -> out_alu_op = 9 with RV32M_EN; out_exc = 1, cause 2, out_regwrite = 0 without it.
